nes_controller_responder: RTL

Controller-side end of the NES joypad serial interface: emulates the 4021 shift register inside a standard NES controller. It captures eight active-high button levels while the console holds latch high, then shifts one bit per console clock rising edge onto the active-low data line. It lets the FPGA act as a controller toward a real console or toward the team's own joypad reader in loopback benches.

---
 rtl/nes_controller_responder.sv | 99 +++++++++
 1 files changed

// File: rtl/nes_controller_responder.sv
// Controller-side NES joypad responder: emulates a 4021 parallel-in/serial-out
// shift register, loading buttons while latch is high and shifting on console clock rises.
module nes_controller_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_900KHz,
    input  logic       reset,
    input  logic       nes_latch,
    input  logic       nes_clk,
    input  logic       a,
    input  logic       b,
    input  logic       select,
    input  logic       start,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    output logic       nes_data,
    output logic [3:0] bit_idx,
    output logic       frame_done,
    output logic       overread
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        SHIFT   = 2'd2,
        DRAINED = 2'd3
    } state_t;

    state_t                 state;
    logic [7:0]             shreg;
    logic [SYNC_STAGES-1:0] latch_pipe;
    logic [SYNC_STAGES-1:0] clk_pipe;
    logic                   clk_prev;
    logic                   latch_sync;
    logic                   clk_sync;
    logic                   clk_rise;
    logic [7:0]             load_val;

    assign latch_sync = latch_pipe[SYNC_STAGES-1];
    assign clk_sync   = clk_pipe[SYNC_STAGES-1];
    assign clk_rise   = clk_sync & ~clk_prev;
    assign load_val   = {~right, ~left, ~down, ~up, ~start, ~select, ~b, ~a};
    assign nes_data   = shreg[0];

    always_ff @(posedge clk_900KHz) begin
        if (!reset) begin
            latch_pipe <= '0;
            clk_pipe   <= '0;
            clk_prev   <= 1'b0;
        end else begin
            latch_pipe <= {latch_pipe[SYNC_STAGES-2:0], nes_latch};
            clk_pipe   <= {clk_pipe[SYNC_STAGES-2:0], nes_clk};
            clk_prev   <= clk_sync;
        end
    end

    // frame_done and overread are single-cycle strobes, valid in the same cycle
    // bit_idx/nes_data change; there is no back-pressure, the consumer must sample every cycle.
    always_ff @(posedge clk_900KHz) begin
        if (!reset) begin
            state      <= IDLE;
            shreg      <= 8'hFF;
            bit_idx    <= 4'd0;
            frame_done <= 1'b0;
            overread   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            overread   <= 1'b0;
            // The latch dominates everything, including a coincident clock rise.
            if (latch_sync) begin
                state   <= LOAD;
                shreg   <= load_val;
                bit_idx <= 4'd0;
            end else begin
                case (state)
                    IDLE: ;
                    LOAD: state <= SHIFT;
                    SHIFT: begin
                        if (clk_rise) begin
                            shreg   <= {1'b0, shreg[7:1]};
                            bit_idx <= bit_idx + 4'd1;
                            if (bit_idx == 4'd7) begin
                                frame_done <= 1'b1;
                                state      <= DRAINED;
                            end
                        end
                    end
                    DRAINED: begin
                        if (clk_rise) overread <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
